// File: rtl/tm_qm_ll_ctrl.sv
// Second-level queue-manager linked-list controller: serialises enqueue/dequeue
// over 1r1w registered-read head/tail/depth/linked-list/descriptor memories.
module tm_qm_ll_ctrl #(
  parameter int QUEUE_ID_NBITS      = 3,
  parameter int QUEUE_ENTRIES_NBITS = 4,
  parameter int DESC_NBITS          = 8
) (
  input  logic                           clk,
  input  logic                           rstn,
  output logic                           init_done,
  input  logic                           enq_req,
  input  logic [QUEUE_ID_NBITS-1:0]      enq_qid,
  input  logic [QUEUE_ENTRIES_NBITS-1:0] enq_ptr,
  input  logic [DESC_NBITS-1:0]          enq_desc,
  output logic                           enq_ack,
  output logic                           enq_drop,
  input  logic                           deq_req,
  input  logic [QUEUE_ID_NBITS-1:0]      deq_qid,
  output logic                           deq_ack,
  output logic                           deq_valid,
  output logic                           deq_empty,
  output logic [QUEUE_ENTRIES_NBITS-1:0] deq_ptr,
  output logic [DESC_NBITS-1:0]          deq_desc,
  output logic                           head_wr,
  output logic [QUEUE_ID_NBITS-1:0]      head_raddr,
  output logic [QUEUE_ID_NBITS-1:0]      head_waddr,
  output logic [QUEUE_ENTRIES_NBITS-1:0] head_wdata,
  input  logic [QUEUE_ENTRIES_NBITS-1:0] head_rdata,
  output logic                           tail_wr,
  output logic [QUEUE_ID_NBITS-1:0]      tail_raddr,
  output logic [QUEUE_ID_NBITS-1:0]      tail_waddr,
  output logic [QUEUE_ENTRIES_NBITS-1:0] tail_wdata,
  input  logic [QUEUE_ENTRIES_NBITS-1:0] tail_rdata,
  output logic                           depth_wr,
  output logic [QUEUE_ID_NBITS-1:0]      depth_raddr,
  output logic [QUEUE_ID_NBITS-1:0]      depth_waddr,
  output logic [QUEUE_ENTRIES_NBITS-1:0] depth_wdata,
  input  logic [QUEUE_ENTRIES_NBITS-1:0] depth_rdata,
  output logic                           depth1_wr,
  output logic [QUEUE_ID_NBITS-1:0]      depth1_waddr,
  output logic [QUEUE_ENTRIES_NBITS-1:0] depth1_wdata,
  output logic                           ll_wr,
  output logic [QUEUE_ENTRIES_NBITS-1:0] ll_raddr,
  output logic [QUEUE_ENTRIES_NBITS-1:0] ll_waddr,
  output logic [QUEUE_ENTRIES_NBITS-1:0] ll_wdata,
  input  logic [QUEUE_ENTRIES_NBITS-1:0] ll_rdata,
  output logic                           pkt_desc_wr,
  output logic [QUEUE_ENTRIES_NBITS-1:0] pkt_desc_raddr,
  output logic [QUEUE_ENTRIES_NBITS-1:0] pkt_desc_waddr,
  output logic [DESC_NBITS-1:0]          pkt_desc_wdata,
  input  logic [DESC_NBITS-1:0]          pkt_desc_rdata
);

  localparam logic [QUEUE_ID_NBITS-1:0]      LAST_QID   = {QUEUE_ID_NBITS{1'b1}};
  localparam logic [QUEUE_ID_NBITS-1:0]      QID_ONE    = {{(QUEUE_ID_NBITS-1){1'b0}}, 1'b1};
  localparam logic [QUEUE_ENTRIES_NBITS-1:0] DEPTH_FULL = {QUEUE_ENTRIES_NBITS{1'b1}};
  localparam logic [QUEUE_ENTRIES_NBITS-1:0] DEPTH_ZERO = {QUEUE_ENTRIES_NBITS{1'b0}};
  localparam logic [QUEUE_ENTRIES_NBITS-1:0] DEPTH_ONE  = {{(QUEUE_ENTRIES_NBITS-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    INIT   = 3'd0,
    IDLE   = 3'd1,
    ENQ_RD = 3'd2,
    DEQ_RD = 3'd3,
    DEQ_LL = 3'd4
  } state_t;

  state_t                           state_r, state_nxt_s;
  logic [QUEUE_ID_NBITS-1:0]        init_cnt_r;
  logic [QUEUE_ID_NBITS-1:0]        qid_r;
  logic [QUEUE_ENTRIES_NBITS-1:0]   ptr_r;
  logic [DESC_NBITS-1:0]            desc_r;
  logic [QUEUE_ENTRIES_NBITS-1:0]   head_r;
  logic [QUEUE_ENTRIES_NBITS-1:0]   depth_r;
  logic                             last_deq_r;
  logic                             grant_enq_s, grant_deq_s;
  logic                             deq_empty_s, deq_done_s;

  // Next state, round-robin grant and memory port drive; writes only in final op states.
  always_comb begin
    state_nxt_s    = state_r;
    grant_enq_s    = 1'b0;
    grant_deq_s    = 1'b0;
    deq_empty_s    = 1'b0;
    deq_done_s     = 1'b0;
    head_wr        = 1'b0;
    head_raddr     = {QUEUE_ID_NBITS{1'b0}};
    head_waddr     = qid_r;
    head_wdata     = ptr_r;
    tail_wr        = 1'b0;
    tail_raddr     = {QUEUE_ID_NBITS{1'b0}};
    tail_waddr     = qid_r;
    tail_wdata     = ptr_r;
    depth_wr       = 1'b0;
    depth_raddr    = {QUEUE_ID_NBITS{1'b0}};
    depth_waddr    = qid_r;
    depth_wdata    = DEPTH_ZERO;
    ll_wr          = 1'b0;
    ll_raddr       = {QUEUE_ENTRIES_NBITS{1'b0}};
    ll_waddr       = tail_rdata;
    ll_wdata       = ptr_r;
    pkt_desc_wr    = 1'b0;
    pkt_desc_raddr = {QUEUE_ENTRIES_NBITS{1'b0}};
    pkt_desc_waddr = ptr_r;
    pkt_desc_wdata = desc_r;
    case (state_r)
      INIT: begin
        // rstn gating keeps the sweep strobe quiet while reset is held
        depth_wr    = rstn;
        depth_waddr = init_cnt_r;
        if (init_cnt_r == LAST_QID) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = INIT;
        end
      end
      IDLE: begin
        if (enq_req && (!deq_req || last_deq_r)) begin
          grant_enq_s = 1'b1;
          tail_raddr  = enq_qid;
          depth_raddr = enq_qid;
          state_nxt_s = ENQ_RD;
        end else if (deq_req) begin
          grant_deq_s = 1'b1;
          head_raddr  = deq_qid;
          depth_raddr = deq_qid;
          state_nxt_s = DEQ_RD;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ENQ_RD: begin
        state_nxt_s = IDLE;
        if (depth_rdata == DEPTH_FULL) begin
          depth_wr = 1'b0;
        end else begin
          tail_wr     = 1'b1;
          depth_wr    = 1'b1;
          pkt_desc_wr = 1'b1;
          depth_wdata = depth_rdata + DEPTH_ONE;
          if (depth_rdata == DEPTH_ZERO) begin
            head_wr = 1'b1;
          end else begin
            ll_wr = 1'b1;
          end
        end
      end
      DEQ_RD: begin
        if (depth_rdata == DEPTH_ZERO) begin
          deq_empty_s = 1'b1;
          deq_done_s  = 1'b1;
          state_nxt_s = IDLE;
        end else begin
          ll_raddr       = head_rdata;
          pkt_desc_raddr = head_rdata;
          state_nxt_s    = DEQ_LL;
        end
      end
      DEQ_LL: begin
        deq_done_s  = 1'b1;
        depth_wr    = 1'b1;
        depth_wdata = depth_r - DEPTH_ONE;
        head_wdata  = ll_rdata;
        if (depth_r > DEPTH_ONE) begin
          head_wr = 1'b1;
        end else begin
          head_wr = 1'b0;
        end
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = INIT;
      end
    endcase
    depth1_wr    = depth_wr;
    depth1_waddr = depth_waddr;
    depth1_wdata = depth_wdata;
  end

  // State, request latches and registered handshake/result outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r    <= INIT;
      init_cnt_r <= {QUEUE_ID_NBITS{1'b0}};
      init_done  <= 1'b0;
      qid_r      <= {QUEUE_ID_NBITS{1'b0}};
      ptr_r      <= {QUEUE_ENTRIES_NBITS{1'b0}};
      desc_r     <= {DESC_NBITS{1'b0}};
      head_r     <= {QUEUE_ENTRIES_NBITS{1'b0}};
      depth_r    <= {QUEUE_ENTRIES_NBITS{1'b0}};
      last_deq_r <= 1'b1;
      enq_ack    <= 1'b0;
      deq_ack    <= 1'b0;
      enq_drop   <= 1'b0;
      deq_valid  <= 1'b0;
      deq_empty  <= 1'b0;
      deq_ptr    <= {QUEUE_ENTRIES_NBITS{1'b0}};
      deq_desc   <= {DESC_NBITS{1'b0}};
    end else begin
      state_r   <= state_nxt_s;
      enq_ack   <= grant_enq_s;
      deq_ack   <= grant_deq_s;
      enq_drop  <= (state_r == ENQ_RD) && (depth_rdata == DEPTH_FULL);
      deq_valid <= deq_done_s;
      deq_empty <= deq_empty_s;
      if (state_r == INIT) begin
        init_cnt_r <= init_cnt_r + QID_ONE;
        if (init_cnt_r == LAST_QID) begin
          init_done <= 1'b1;
        end
      end
      if (grant_enq_s) begin
        qid_r      <= enq_qid;
        ptr_r      <= enq_ptr;
        desc_r     <= enq_desc;
        last_deq_r <= 1'b0;
      end else if (grant_deq_s) begin
        qid_r      <= deq_qid;
        last_deq_r <= 1'b1;
      end
      if (state_r == DEQ_RD) begin
        head_r  <= head_rdata;
        depth_r <= depth_rdata;
      end
      if (deq_empty_s) begin
        deq_ptr <= {QUEUE_ENTRIES_NBITS{1'b0}};
      end else if (state_r == DEQ_LL) begin
        deq_ptr  <= head_r;
        deq_desc <= pkt_desc_rdata;
      end
    end
  end

endmodule

// File: tb/tb_tm_qm_ll_ctrl.sv
// Directed bench for tm_qm_ll_ctrl with behavioural 1r1w registered-read memories.
module tb_tm_qm_ll_ctrl;
  localparam int QN = 3;
  localparam int EN = 4;
  localparam int DN = 8;
  localparam int NQ = 8;
  localparam int NE = 16;

  logic clk = 1'b0;
  logic rstn;
  logic init_done;
  logic enq_req, enq_ack, enq_drop;
  logic [QN-1:0] enq_qid;
  logic [EN-1:0] enq_ptr;
  logic [DN-1:0] enq_desc;
  logic deq_req, deq_ack, deq_valid, deq_empty;
  logic [QN-1:0] deq_qid;
  logic [EN-1:0] deq_ptr;
  logic [DN-1:0] deq_desc;
  logic head_wr, tail_wr, depth_wr, depth1_wr, ll_wr, pkt_desc_wr;
  logic [QN-1:0] head_raddr, head_waddr, tail_raddr, tail_waddr, depth_raddr, depth_waddr, depth1_waddr;
  logic [EN-1:0] head_wdata, head_rdata, tail_wdata, tail_rdata, depth_wdata, depth_rdata, depth1_wdata;
  logic [EN-1:0] ll_raddr, ll_waddr, ll_wdata, ll_rdata, pkt_desc_raddr, pkt_desc_waddr;
  logic [DN-1:0] pkt_desc_wdata, pkt_desc_rdata;

  logic [EN-1:0] head_mem [NQ];
  logic [EN-1:0] tail_mem [NQ];
  logic [EN-1:0] depth_mem [NQ];
  logic [EN-1:0] depth1_mem [NQ];
  logic [EN-1:0] ll_mem [NE];
  logic [DN-1:0] desc_mem [NE];
  int wr_cnt = 0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tm_qm_ll_ctrl #(.QUEUE_ID_NBITS(QN), .QUEUE_ENTRIES_NBITS(EN), .DESC_NBITS(DN)) dut (
    .clk(clk), .rstn(rstn), .init_done(init_done),
    .enq_req(enq_req), .enq_qid(enq_qid), .enq_ptr(enq_ptr), .enq_desc(enq_desc),
    .enq_ack(enq_ack), .enq_drop(enq_drop),
    .deq_req(deq_req), .deq_qid(deq_qid), .deq_ack(deq_ack), .deq_valid(deq_valid),
    .deq_empty(deq_empty), .deq_ptr(deq_ptr), .deq_desc(deq_desc),
    .head_wr(head_wr), .head_raddr(head_raddr), .head_waddr(head_waddr), .head_wdata(head_wdata), .head_rdata(head_rdata),
    .tail_wr(tail_wr), .tail_raddr(tail_raddr), .tail_waddr(tail_waddr), .tail_wdata(tail_wdata), .tail_rdata(tail_rdata),
    .depth_wr(depth_wr), .depth_raddr(depth_raddr), .depth_waddr(depth_waddr), .depth_wdata(depth_wdata), .depth_rdata(depth_rdata),
    .depth1_wr(depth1_wr), .depth1_waddr(depth1_waddr), .depth1_wdata(depth1_wdata),
    .ll_wr(ll_wr), .ll_raddr(ll_raddr), .ll_waddr(ll_waddr), .ll_wdata(ll_wdata), .ll_rdata(ll_rdata),
    .pkt_desc_wr(pkt_desc_wr), .pkt_desc_raddr(pkt_desc_raddr), .pkt_desc_waddr(pkt_desc_waddr),
    .pkt_desc_wdata(pkt_desc_wdata), .pkt_desc_rdata(pkt_desc_rdata)
  );

  // Memory models; depth is poisoned while reset is held so the clear sweep is observable.
  always @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < NQ; i++) begin
        depth_mem[i]  <= 4'd7;
        depth1_mem[i] <= 4'd7;
      end
    end else begin
      if (depth_wr)  depth_mem[depth_waddr]   <= depth_wdata;
      if (depth1_wr) depth1_mem[depth1_waddr] <= depth1_wdata;
    end
    if (head_wr)     head_mem[head_waddr]     <= head_wdata;
    if (tail_wr)     tail_mem[tail_waddr]     <= tail_wdata;
    if (ll_wr)       ll_mem[ll_waddr]         <= ll_wdata;
    if (pkt_desc_wr) desc_mem[pkt_desc_waddr] <= pkt_desc_wdata;
    head_rdata     <= head_mem[head_raddr];
    tail_rdata     <= tail_mem[tail_raddr];
    depth_rdata    <= depth_mem[depth_raddr];
    ll_rdata       <= ll_mem[ll_raddr];
    pkt_desc_rdata <= desc_mem[pkt_desc_raddr];
  end

  always @(negedge clk) begin
    if (head_wr || tail_wr || depth_wr || depth1_wr || ll_wr || pkt_desc_wr) wr_cnt <= wr_cnt + 1;
  end

  task automatic enq_op(input logic [QN-1:0] q, input logic [EN-1:0] p, input logic [DN-1:0] d,
                        output logic dropped);
    logic acked = 1'b0;
    enq_qid = q; enq_ptr = p; enq_desc = d; enq_req = 1'b1;
    for (int i = 0; i < 20 && !acked; i++) begin
      @(posedge clk); #1;
      if (enq_ack) acked = 1'b1;
    end
    enq_req = 1'b0;
    dropped = 1'b0;
    checks++;
    if (!acked) begin
      errors++; $display("FAIL enq_ack_timeout got=0 want=1");
    end else begin
      @(posedge clk); #1;
      dropped = enq_drop;
    end
  endtask

  task automatic deq_op(input logic [QN-1:0] q, output logic empty, output logic [EN-1:0] p,
                        output logic [DN-1:0] d);
    logic acked = 1'b0;
    logic got = 1'b0;
    deq_qid = q; deq_req = 1'b1;
    for (int i = 0; i < 20 && !acked; i++) begin
      @(posedge clk); #1;
      if (deq_ack) acked = 1'b1;
    end
    deq_req = 1'b0;
    for (int i = 0; i < 6 && !got; i++) begin
      @(posedge clk); #1;
      if (deq_valid) got = 1'b1;
    end
    empty = deq_empty; p = deq_ptr; d = deq_desc;
    checks++;
    if (!got) begin
      errors++; $display("FAIL deq_valid_timeout acked=%0b got=0 want=1", acked);
    end
  endtask

  task automatic wait_init(input string tag);
    int cyc = 0;
    do begin
      @(posedge clk); #1; cyc++;
    end while (!init_done && cyc < 40);
    checks++;
    if (cyc !== 8) begin
      errors++; $display("FAIL %s_init_cycles got=%0d want=8", tag, cyc);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({init_done, enq_ack, deq_ack, enq_drop, deq_valid, deq_empty} !== 6'b0 || deq_ptr !== 4'd0 ||
        deq_desc !== 8'd0 || {head_wr, tail_wr, depth_wr, depth1_wr, ll_wr, pkt_desc_wr} !== 6'b0) begin
      errors++; $display("FAIL reset_outputs got=%b/%h/%h want=0", {init_done, enq_ack, deq_ack, enq_drop,
        deq_valid, deq_empty, head_wr, tail_wr, depth_wr, depth1_wr, ll_wr, pkt_desc_wr}, deq_ptr, deq_desc);
    end
    @(negedge clk) rstn = 1'b1;
    wait_init("reset");
    checks++;
    if (depth_mem[0] !== 4'd0 || depth_mem[5] !== 4'd0 || depth_mem[7] !== 4'd0 || depth1_mem[7] !== 4'd0) begin
      errors++; $display("FAIL reset_depth_clear got=%h %h %h %h want=0", depth_mem[0], depth_mem[5],
        depth_mem[7], depth1_mem[7]);
    end
  endtask

  task automatic test_round_robin();
    string seq = "";
    int n = 0;
    enq_qid = 3'd3; enq_ptr = 4'd4; enq_desc = 8'h44; deq_qid = 3'd3;
    enq_req = 1'b1; deq_req = 1'b1;
    for (int i = 0; i < 60 && n < 6; i++) begin
      @(posedge clk); #1;
      if (enq_ack) begin seq = {seq, "E"}; n++; end
      if (deq_ack) begin seq = {seq, "D"}; n++; end
    end
    enq_req = 1'b0; deq_req = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (seq != "EDEDED") begin
      errors++; $display("FAIL rr_order got=%s want=EDEDED", seq);
    end
    checks++;
    if (depth_mem[3] !== 4'd0) begin
      errors++; $display("FAIL rr_depth got=%0d want=0", depth_mem[3]);
    end
  endtask

  task automatic test_enq_deq_order();
    logic dr, em;
    logic [EN-1:0] p;
    logic [DN-1:0] d;
    logic [EN-1:0] ptrs [3];
    logic [DN-1:0] descs [3];
    ptrs = '{4'd3, 4'd7, 4'd9};
    descs = '{8'hA3, 8'hB7, 8'hC9};
    for (int i = 0; i < 3; i++) begin
      enq_op(3'd2, ptrs[i], descs[i], dr);
      checks++;
      if (dr !== 1'b0) begin errors++; $display("FAIL order_enq_drop%0d got=1 want=0", i); end
    end
    checks++;
    if (depth_mem[2] !== 4'd3 || depth1_mem[2] !== 4'd3) begin
      errors++; $display("FAIL order_depth_init got=%0d/%0d want=3", depth_mem[2], depth1_mem[2]);
    end
    for (int i = 0; i < 3; i++) begin
      deq_op(3'd2, em, p, d);
      checks++;
      if (em !== 1'b0 || p !== ptrs[i] || d !== descs[i]) begin
        errors++; $display("FAIL order_deq%0d got=%b/%0d/%h want=0/%0d/%h", i, em, p, d, ptrs[i], descs[i]);
      end
      checks++;
      if (depth_mem[2] !== 4'(2 - i) || depth1_mem[2] !== 4'(2 - i)) begin
        errors++; $display("FAIL order_depth%0d got=%0d/%0d want=%0d", i, depth_mem[2], depth1_mem[2], 2 - i);
      end
    end
    checks++;
    if (deq_ptr !== 4'd9 || deq_desc !== 8'hC9) begin
      errors++; $display("FAIL order_hold got=%0d/%h want=9/c9", deq_ptr, deq_desc);
    end
  endtask

  task automatic test_deq_empty();
    logic em;
    logic [EN-1:0] p;
    logic [DN-1:0] d;
    int w0 = wr_cnt;
    deq_op(3'd4, em, p, d);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (em !== 1'b1 || p !== 4'd0) begin
      errors++; $display("FAIL empty_result got=%b/%0d want=1/0", em, p);
    end
    checks++;
    if (wr_cnt !== w0) begin
      errors++; $display("FAIL empty_no_write got=%0d want=0", wr_cnt - w0);
    end
  endtask

  task automatic test_full_drop();
    logic dr;
    logic [EN-1:0] t0;
    int drops = 0;
    for (int i = 0; i < 15; i++) begin
      enq_op(3'd1, 4'(i), 8'(i + 16), dr);
      if (dr) drops++;
    end
    checks++;
    if (drops !== 0 || depth_mem[1] !== 4'd15) begin
      errors++; $display("FAIL full_fill got=drops%0d/depth%0d want=0/15", drops, depth_mem[1]);
    end
    t0 = tail_mem[1];
    enq_op(3'd1, 4'd15, 8'hFF, dr);
    checks++;
    if (dr !== 1'b1) begin errors++; $display("FAIL full_drop got=%b want=1", dr); end
    @(posedge clk); #1;
    checks++;
    if (tail_mem[1] !== t0 || t0 !== 4'd14 || depth_mem[1] !== 4'd15) begin
      errors++; $display("FAIL full_unchanged got=tail%0d/depth%0d want=14/15", tail_mem[1], depth_mem[1]);
    end
  endtask

  task automatic test_midop_reset();
    logic dr, em, seen;
    logic [EN-1:0] p;
    logic [DN-1:0] d;
    int w0;
    enq_op(3'd6, 4'd2, 8'h62, dr);
    deq_qid = 3'd6; deq_req = 1'b1;
    for (int i = 0; i < 20 && !deq_ack; i++) begin
      @(posedge clk); #1;
    end
    deq_req = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b0;
    w0 = wr_cnt;
    seen = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (deq_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0 || wr_cnt !== w0) begin
      errors++; $display("FAIL midrst_quiet got=valid%b/writes%0d want=0/0", seen, wr_cnt - w0);
    end
    @(negedge clk) rstn = 1'b1;
    wait_init("midrst");
    checks++;
    if (depth_mem[6] !== 4'd0) begin
      errors++; $display("FAIL midrst_depth got=%0d want=0", depth_mem[6]);
    end
    deq_op(3'd6, em, p, d);
    checks++;
    if (em !== 1'b1) begin errors++; $display("FAIL midrst_empty got=%b want=1", em); end
  endtask

  initial begin
    rstn = 1'b0; enq_req = 1'b0; deq_req = 1'b0;
    enq_qid = 3'd0; enq_ptr = 4'd0; enq_desc = 8'd0; deq_qid = 3'd0;
    test_reset();
    test_round_robin();
    test_enq_deq_order();
    test_deq_empty();
    test_full_drop();
    test_midop_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
